sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/debounce_chan.sv | 74 +++++++
 rtl/sw_debounce.sv | 34 +++
 tb/tb_sw_debounce.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the switch debouncer.
package sw_debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_t;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: two-flop synchroniser, stability counter, edge pulses.
module debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw_raw,
    output logic o_sw_db,
    output logic o_sw_rise,
    output logic o_sw_fall,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_diff;
    logic             w_accept;
    logic             w_db_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    edge_t            w_edge;

    assign w_diff   = (r_s2 != r_db);
    assign w_accept = w_diff && (r_cnt == CNT_MAX);

    // Any cycle agreeing with the accepted level drops the pending change.
    always_comb begin
        w_cnt_nxt = '0;
        w_db_nxt  = r_db;
        w_edge    = EDGE_NONE;
        if (w_accept) begin
            w_db_nxt = r_s2;
            w_edge   = r_s2 ? EDGE_RISE : EDGE_FALL;
        end else if (w_diff) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_s1   <= i_sw_raw;
            r_s2   <= r_s1;
            r_cnt  <= w_cnt_nxt;
            r_db   <= w_db_nxt;
            r_rise <= (w_edge == EDGE_RISE);
            r_fall <= (w_edge == EDGE_FALL);
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign o_sw_db   = r_db;
    assign o_sw_rise = r_rise;
    assign o_sw_fall = r_fall;
    assign o_busy    = r_busy;

endmodule

// File: rtl/sw_debounce.sv
// Board switch conditioning: N_SW independent debounce channels.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned N_SW            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    for (genvar g = 0; g < int'(N_SW); g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_sw_raw  (sw_raw[g]),
            .o_sw_db   (sw_db[g]),
            .o_sw_rise (sw_rise[g]),
            .o_sw_fall (sw_fall[g]),
            .o_busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a sample-history reference model.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw_raw;
    logic [1:0] sw_db;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic [1:0] busy;

    int checks   = 0;
    int failures = 0;

    sw_debounce #(
        .N_SW            (2),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a new level is accepted once the last D synchronised samples
    // (raw samples two edges old) all differ from the accepted level.
    logic [D:0] hist [2];
    logic [1:0] m_db, m_rise, m_fall, m_busy;
    logic       acc_m;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                hist[c]   = '0;
                m_db[c]   = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                m_busy[c] = 1'b0;
            end else begin
                acc_m = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[c][j] == m_db[c]) acc_m = 1'b0;
                m_busy[c] = (hist[c][1] != m_db[c]) && !acc_m;
                m_rise[c] = acc_m && !m_db[c];
                m_fall[c] = acc_m && m_db[c];
                if (acc_m) m_db[c] = ~m_db[c];
                hist[c] = {hist[c][D-1:0], sw_raw[c]};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first;
        sw_raw = 2'b11;
        rst_n  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({sw_db, sw_rise, sw_fall, busy} !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold got db=%b r=%b f=%b b=%b exp all 0", sw_db, sw_rise, sw_fall, busy);
            end
        end
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if ({sw_db, sw_rise, sw_fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
                failures++;
                $display("FAIL reset_release_model n=%0d got db=%b r=%b f=%b b=%b exp db=%b r=%b f=%b b=%b",
                         n, sw_db, sw_rise, sw_fall, busy, m_db, m_rise, m_fall, m_busy);
            end
            if (first == 0 && sw_db == 2'b11) begin
                first = n;
                checks++;
                if (sw_rise !== 2'b11) begin
                    failures++;
                    $display("FAIL reset_release_rise got %b exp 11", sw_rise);
                end
            end
            if (n == 7) begin
                checks++;
                if (sw_rise !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_release_rise_clear got %b exp 00", sw_rise);
                end
            end
        end
        checks++;
        if (first != 6) begin
            failures++;
            $display("FAIL reset_release_latency got %0d exp 6", first);
        end
    endtask

    task automatic test_press();
        int first;
        for (int phase = 0; phase < 2; phase++) begin
            sw_raw[0] = (phase == 1);
            first = 0;
            for (int n = 1; n <= 12; n++) begin
                tick();
                checks++;
                if ({sw_db, sw_rise, sw_fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
                    failures++;
                    $display("FAIL press_model ph=%0d n=%0d got db=%b r=%b f=%b b=%b exp db=%b r=%b f=%b b=%b",
                             phase, n, sw_db, sw_rise, sw_fall, busy, m_db, m_rise, m_fall, m_busy);
                end
                if (first == 0 && (phase == 1 ? sw_rise[0] : sw_fall[0])) first = n;
                if (n == 3) begin
                    checks++;
                    if (busy[0] !== 1'b1) begin
                        failures++;
                        $display("FAIL press_busy ph=%0d got %b exp 1", phase, busy[0]);
                    end
                end
            end
            checks++;
            if (first != 6 || sw_db[0] !== (phase == 1)) begin
                failures++;
                $display("FAIL press_latency ph=%0d got edge=%0d db0=%b exp edge=6 db0=%0d",
                         phase, first, sw_db[0], phase);
            end
        end
    endtask

    task automatic test_bounce();
        int bounce_pulses;
        int rises;
        int first;
        sw_raw = 2'b00;
        for (int n = 0; n < 10; n++) tick();
        bounce_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            sw_raw[1] = (k % 2 == 0);
            for (int n = 0; n < 2; n++) begin
                tick();
                if (sw_rise[1] || sw_fall[1]) bounce_pulses++;
                checks++;
                if ({sw_db, sw_rise, sw_fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
                    failures++;
                    $display("FAIL bounce_model k=%0d got db=%b r=%b f=%b b=%b exp db=%b r=%b f=%b b=%b",
                             k, sw_db, sw_rise, sw_fall, busy, m_db, m_rise, m_fall, m_busy);
                end
            end
        end
        sw_raw[1] = 1'b1;
        rises = 0;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (sw_rise[1]) begin
                rises++;
                if (first == 0) first = n;
            end
        end
        checks++;
        if (bounce_pulses != 0 || rises != 1 || first != 6) begin
            failures++;
            $display("FAIL bounce got pulses=%0d rises=%0d edge=%0d exp 0 1 6", bounce_pulses, rises, first);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        int busy_seen;
        pulses    = 0;
        busy_seen = 0;
        sw_raw[0] = 1'b1;
        for (int n = 0; n < 13; n++) begin
            if (n == 3) sw_raw[0] = 1'b0;
            tick();
            if (sw_rise[0] || sw_fall[0] || sw_db[0]) pulses++;
            if (busy[0]) busy_seen++;
            checks++;
            if ({sw_db, sw_rise, sw_fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
                failures++;
                $display("FAIL glitch_model n=%0d got db=%b r=%b f=%b b=%b exp db=%b r=%b f=%b b=%b",
                         n, sw_db, sw_rise, sw_fall, busy, m_db, m_rise, m_fall, m_busy);
            end
        end
        checks++;
        if (pulses != 0 || busy_seen != 3 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch got pulses=%0d busy_cycles=%0d busy0=%b exp 0 3 0", pulses, busy_seen, busy[0]);
        end
    endtask

    task automatic test_simultaneous();
        int first;
        sw_raw = 2'b01;
        first  = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (first == 0 && sw_db == 2'b01) begin
                first = n;
                checks++;
                if (sw_rise !== 2'b01 || sw_fall !== 2'b10) begin
                    failures++;
                    $display("FAIL simul_pulses got r=%b f=%b exp r=01 f=10", sw_rise, sw_fall);
                end
            end
        end
        checks++;
        if (first != 6) begin
            failures++;
            $display("FAIL simul_latency got %0d exp 6", first);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        sw_raw[1] = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before got %b exp 1", busy[1]);
        end
        rst_n  = 1'b0;
        sw_raw = 2'b00;
        tick();
        checks++;
        if ({sw_db, sw_rise, sw_fall, busy} !== 8'h00) begin
            failures++;
            $display("FAIL midreset_clear got db=%b r=%b f=%b b=%b exp all 0", sw_db, sw_rise, sw_fall, busy);
        end
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (sw_rise != 2'b00 || sw_fall != 2'b00 || sw_db != 2'b00) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midreset_after got %0d active cycles exp 0", pulses);
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 80; seg++) begin
            sw_raw = 2'($urandom_range(0, 3));
            len    = $urandom_range(1, 7);
            for (int n = 0; n < len; n++) begin
                tick();
                checks++;
                if ({sw_db, sw_rise, sw_fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
                    failures++;
                    $display("FAIL random_model seg=%0d got db=%b r=%b f=%b b=%b exp db=%b r=%b f=%b b=%b",
                             seg, sw_db, sw_rise, sw_fall, busy, m_db, m_rise, m_fall, m_busy);
                end
                checks++;
                if ((sw_rise & sw_fall) !== 2'b00) begin
                    failures++;
                    $display("FAIL random_exclusive got r=%b f=%b exp no overlap", sw_rise, sw_fall);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sw_raw = 2'b00;
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
